tx_flex_serializer: RTL and testbench
=====================================

TX_FLEX_SERIALIZER -- requirements
Module: tx_flex_serializer

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Localparam CNT_W SHALL be $clog2(WIDTH), the bit-counter width; it is not user-overridable.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 P_DATA  input  WIDTH  parallel word to transmit.
REQ-006 DATA_VALID  input  1  P_DATA is valid this cycle.
REQ-007 READY  output  1  the block can accept a word this cycle.
REQ-008 SER_ENABLE  input  1  advance one bit this cycle; driven by the frame controller.
REQ-009 MSB_FIRST  input  1  bit order: 1 = MSB first, 0 = LSB first; sampled per word at acceptance.
REQ-010 PAR_TYP  input  1  parity type: 0 = even, 1 = odd; sampled per word at acceptance.
REQ-011 SER_DATA  output  1  current serial bit.
REQ-012 SER_DONE  output  1  one-cycle pulse: the last bit of a word has been consumed.
REQ-013 PAR_BIT  output  1  parity of the word currently in the shifter.
REQ-014 BUSY  output  1  shifter holds a word (state SHIFT).

Function
REQ-015 States SHALL be IDLE and SHIFT; SHIFT comprises a shift register, a bit counter cnt[CNT_W-1:0], and a one-entry holding buffer (data, order bit, parity-type bit, full flag).
REQ-016 READY SHALL equal NOT buffer_full, combinationally; accept = DATA_VALID & READY.
REQ-017 Accept in IDLE SHALL load P_DATA into the shifter at that edge: state -> SHIFT, cnt = 0, order and parity latched; the buffer remains empty.
REQ-018 Accept in SHIFT SHALL write P_DATA, MSB_FIRST and PAR_TYP into the buffer and set buffer_full.
REQ-019 SER_DATA SHALL be shreg[WIDTH-1] when the latched order is MSB-first, else shreg[0]; in IDLE it SHALL be 0.
REQ-020 SER_ENABLE in SHIFT with cnt < WIDTH-1 SHALL shift the register one position toward the output bit and increment cnt.
REQ-021 SER_ENABLE in SHIFT with cnt == WIDTH-1 (last bit) SHALL set SER_DONE high for exactly the next cycle.
REQ-022 At the last-bit edge: if the buffer is full, the buffer SHALL be moved to the shifter, cnt = 0, buffer_full cleared, and the block stays in SHIFT; otherwise the state SHALL go to IDLE.
REQ-023 Accept and last-bit SER_ENABLE in the same SHIFT cycle with the buffer empty: the new word SHALL load directly into the shifter and the state stays SHIFT (no bubble).
REQ-024 SER_ENABLE in IDLE SHALL be ignored: no state change and no SER_DONE.
REQ-025 DATA_VALID while READY = 0 SHALL be ignored; the buffered word is never overwritten.
REQ-026 PAR_BIT SHALL be registered at every shifter load as XOR(word) XOR latched PAR_TYP, and held until the next load.
REQ-027 cnt SHALL never exceed WIDTH-1 and SHALL not wrap within a word.
REQ-028 BUSY SHALL be 1 exactly when the state is SHIFT.

Reset
REQ-029 While RST = 0: state = IDLE, shreg = 0, cnt = 0, buffer cleared, PAR_BIT = 0, SER_DONE = 0, SER_DATA = 0, BUSY = 0, READY = 1.
REQ-030 Reset asserted mid-word SHALL discard both the shifter word and the buffered word immediately (asynchronously), with no SER_DONE.

Verification
REQ-031 WIDTH=8, LSB-first, P_DATA=0xA5, PAR_TYP=0, SER_ENABLE held high -> SER_DATA 1,0,1,0,0,1,0,1; PAR_BIT=0; SER_DONE pulses once; BUSY falls at the same edge.
REQ-032 Same word with MSB_FIRST=1, PAR_TYP=1 -> SER_DATA 1,0,1,0,0,1,0,1 (MSB first); PAR_BIT=1.
REQ-033 0x3C accepted, then 0xF0 accepted mid-word, then a third word offered -> READY=0, third word ignored; 0xF0 starts the cycle after the 0x3C SER_DONE with no gap; 16 bits in total.
REQ-034 SER_ENABLE toggled 1/0 every cycle; SER_ENABLE pulses while IDLE -> bits advance only on high cycles; no SER_DONE from IDLE pulses.
REQ-035 RST driven low after 3 bits with the buffer full -> all outputs take reset values asynchronously; after release READY=1 and BUSY=0.
REQ-036 WIDTH=5 instance, P_DATA=5'b10011, LSB-first -> 5 bits 1,1,0,0,1; SER_DONE after the 5th bit; PAR_BIT=1.

Source files
------------

// File: rtl/tx_flex_serializer.sv
// tx_flex_serializer: parallel-to-serial shifter with one-word holding buffer, selectable bit order and parity
module tx_flex_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    output logic             READY,
    input  logic             SER_ENABLE,
    input  logic             MSB_FIRST,
    input  logic             PAR_TYP,
    output logic             SER_DATA,
    output logic             SER_DONE,
    output logic             PAR_BIT,
    output logic             BUSY
);
    localparam int CNT_W = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] shreg, buf_data, ld_data;
    logic [CNT_W-1:0] cnt;
    logic             order, buf_order, buf_ptyp, buf_full;
    logic             accept, last, load, ld_order, ld_ptyp;
    assign READY    = ~buf_full;
    assign accept   = DATA_VALID & READY;
    assign BUSY     = state == SHIFT;
    assign last     = BUSY && SER_ENABLE && cnt == CNT_W'(WIDTH - 1);
    assign load     = (!BUSY && accept) || (last && (buf_full || accept));
    assign SER_DATA = BUSY && (order ? shreg[WIDTH-1] : shreg[0]);
    // a pending buffered word always takes priority over the input port when the shifter reloads
    always_comb begin
        ld_data  = buf_full ? buf_data  : P_DATA;
        ld_order = buf_full ? buf_order : MSB_FIRST;
        ld_ptyp  = buf_full ? buf_ptyp  : PAR_TYP;
    end
    // shifter, bit counter, holding buffer and registered status outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            order     <= 1'b0;
            buf_data  <= '0;
            buf_order <= 1'b0;
            buf_ptyp  <= 1'b0;
            buf_full  <= 1'b0;
            PAR_BIT   <= 1'b0;
            SER_DONE  <= 1'b0;
        end else begin
            SER_DONE <= last;
            if (load) begin
                state   <= SHIFT;
                shreg   <= ld_data;
                order   <= ld_order;
                PAR_BIT <= ^ld_data ^ ld_ptyp;
                cnt     <= '0;
            end else if (last) begin
                state <= IDLE;
            end else if (BUSY && SER_ENABLE) begin
                shreg <= order ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                cnt   <= cnt + 1'b1;
            end
            if (BUSY && accept && !last) begin
                buf_data  <= P_DATA;
                buf_order <= MSB_FIRST;
                buf_ptyp  <= PAR_TYP;
                buf_full  <= 1'b1;
            end else if (last && buf_full) begin
                buf_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tx_flex_serializer.sv
// tb_tx_flex_serializer: randomized scoreboard bench for tx_flex_serializer plus a WIDTH=5 directed check
module tb_tx_flex_serializer;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       DATA_VALID = 1'b0, SER_ENABLE = 1'b0, MSB_FIRST = 1'b0, PAR_TYP = 1'b0;
    logic       READY, SER_DATA, SER_DONE, PAR_BIT, BUSY;
    logic [4:0] d5 = '0;
    logic       v5 = 1'b0, en5 = 1'b0, msb5 = 1'b0, par5 = 1'b0;
    logic       ready5, ser5, done5, parb5, busy5;
    int         compared = 0, mismatched = 0;

    typedef struct {logic b; logic last; logic par;} ent_t;
    ent_t q[$];
    ent_t e;
    logic done_exp = 1'b0;
    int   nw;

    always #5 CLK = ~CLK;

    tx_flex_serializer #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .READY(READY),
        .SER_ENABLE(SER_ENABLE), .MSB_FIRST(MSB_FIRST), .PAR_TYP(PAR_TYP),
        .SER_DATA(SER_DATA), .SER_DONE(SER_DONE), .PAR_BIT(PAR_BIT), .BUSY(BUSY)
    );

    tx_flex_serializer #(.WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(d5), .DATA_VALID(v5), .READY(ready5),
        .SER_ENABLE(en5), .MSB_FIRST(msb5), .PAR_TYP(par5),
        .SER_DATA(ser5), .SER_DONE(done5), .PAR_BIT(parb5), .BUSY(busy5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic m, input logic p, input logic en);
        DATA_VALID = v;
        P_DATA     = d;
        MSB_FIRST  = m;
        PAR_TYP    = p;
        SER_ENABLE = en;
        @(posedge CLK);
        #1;
    endtask

    // scoreboard monitor: words are queued as bit streams on acceptance, popped as the DUT consumes them
    always @(negedge CLK) begin
        if (RST) begin
            nw = 0;
            foreach (q[i]) if (q[i].last) nw++;
            chk("busy", BUSY, q.size() != 0);
            chk("ready", READY, nw < 2);
            chk("ser_done", SER_DONE, done_exp);
            done_exp = 1'b0;
            if (q.size() == 0) begin
                chk("ser_data_idle", SER_DATA, 0);
            end else begin
                chk("par_bit", PAR_BIT, q[0].par);
                if (SER_ENABLE) begin
                    e = q.pop_front();
                    chk("ser_data", SER_DATA, e.b);
                    done_exp = e.last;
                end
            end
            if (DATA_VALID && nw < 2)
                for (int i = 0; i < 8; i++) begin
                    e.b    = MSB_FIRST ? P_DATA[7-i] : P_DATA[i];
                    e.last = (i == 7);
                    e.par  = ($countones(P_DATA) % 2 == 1) ^ PAR_TYP;
                    q.push_back(e);
                end
        end
    end

    initial begin
        logic [4:0] w5;
        #3;
        chk("rst_ready", READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_ser_data", SER_DATA, 0);
        chk("rst_ser_done", SER_DONE, 0);
        chk("rst_par_bit", PAR_BIT, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        step(0, 8'h00, 0, 0, 0);
        // LSB-first 0xA5 even parity, then MSB-first 0xA5 odd parity
        step(1, 8'hA5, 0, 0, 1);
        repeat (10) step(0, 8'h00, 0, 0, 1);
        step(1, 8'hA5, 1, 1, 1);
        repeat (10) step(0, 8'h00, 0, 0, 1);
        // back-to-back words with a third offered while the buffer is full
        step(1, 8'h3C, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'hF0, 1, 0, 1);
        step(1, 8'h55, 0, 1, 1);
        step(1, 8'h55, 0, 1, 1);
        repeat (16) step(0, 8'h00, 0, 0, 1);
        // enable toggling mid-word and pulses while idle
        step(1, 8'h96, 0, 1, 0);
        repeat (20) begin
            step(0, 8'h00, 0, 0, 1);
            step(0, 8'h00, 0, 0, 0);
        end
        repeat (300) step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 8'h00, 0, 0, 1);
        chk("drain_timeout", q.size(), 0);
        // asynchronous reset mid-word with the buffer full
        step(1, 8'hC3, 0, 0, 0);
        step(1, 8'h81, 1, 1, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        #1;
        RST = 1'b0;
        #1;
        chk("arst_ready", READY, 1);
        chk("arst_busy", BUSY, 0);
        chk("arst_ser_data", SER_DATA, 0);
        chk("arst_ser_done", SER_DONE, 0);
        chk("arst_par_bit", PAR_BIT, 0);
        q.delete();
        done_exp = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        // WIDTH=5 instance, LSB-first 5'b10011 even parity
        w5 = 5'b10011;
        v5 = 1'b1;
        d5 = w5;
        @(posedge CLK);
        #1;
        v5  = 1'b0;
        en5 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("w5_bit", ser5, w5[i]);
            chk("w5_done_early", done5, 0);
            if (i == 0) chk("w5_par", parb5, 1);
        end
        @(negedge CLK);
        chk("w5_done", done5, 1);
        chk("w5_busy", busy5, 0);
        @(negedge CLK);
        chk("w5_done_pulse", done5, 0);
        en5 = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
